lms_fir_lanes: RTL and testbench

- Parametrised LMS adaptive FIR, successor to the single-MAC-pair adaptive FIR; sits between the controller and the output sample path.
- Per sample: shifts `x_in` into the delay line, optionally updates every weight as w += (weight_adjust·x), then outputs sat(a_in + Σ w·x).
- LANES parallel update/MAC lanes cut per-sample latency from ~TAPS to TAPS/LANES.
- Adds freeze mode, synchronous weight clear, busy flag and overrun detection.

---
 rtl/lms_fir_lanes_if.sv | 40 ++++
 rtl/lms_fir_lanes.sv | 252 +++++++++++++++++++++++++
 tb/tb_lms_fir_lanes.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lms_fir_lanes_if.sv
// lms_fir_lanes_if: controller-side bundle for the lane-parallel LMS adaptive FIR.
//   master : controller (drives sample, additive term, update coefficient, controls)
//   slave  : filter     (returns busy, result, strobes)
// Signals:
//   x_in          DW  new reference sample (signed Q1.(DW-1))
//   a_in          DW  additive term for the output (signed)
//   weight_adjust DW  mu*error update coefficient (signed)
//   adapt_en      1   1 = update weights during this run
//   weight_clr    1   clear all weights (accepted only while idle)
//   fir_go        1   start pulse
//   busy          1   run in progress
//   out_sample    DW  saturated result (signed)
//   out_valid     1   one-cycle strobe with out_sample
//   done          1   one-cycle strobe, same cycle as out_valid
//   overrun       1   one-cycle strobe: fir_go arrived while busy
interface lms_fir_lanes_if #(
    parameter int DW = 16
);
    logic signed [DW-1:0] x_in;
    logic signed [DW-1:0] a_in;
    logic signed [DW-1:0] weight_adjust;
    logic                 adapt_en;
    logic                 weight_clr;
    logic                 fir_go;
    logic                 busy;
    logic signed [DW-1:0] out_sample;
    logic                 out_valid;
    logic                 done;
    logic                 overrun;

    modport master (
        output x_in, a_in, weight_adjust, adapt_en, weight_clr, fir_go,
        input  busy, out_sample, out_valid, done, overrun
    );

    modport slave (
        input  x_in, a_in, weight_adjust, adapt_en, weight_clr, fir_go,
        output busy, out_sample, out_valid, done, overrun
    );
endinterface

// File: rtl/lms_fir_lanes.sv
// lms_fir_lanes: LMS adaptive FIR with LANES parallel update/MAC lanes.
// Per accepted fir_go the delay line shifts in x_in, every weight is optionally
// updated by w += (weight_adjust*x) >>> (DW-1) (saturated), and the result
// sat(a_in + sum(w*x)) is presented exactly TAPS/LANES + 5 cycles later.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears delay line, weights, pipeline)
//   bus    lms_fir_lanes_if.slave (sample/control inputs, result/status outputs)
// Pipeline per group of LANES taps: read -> update multiply -> weight write
// -> output multiply -> accumulate; one group issues per cycle in RUN.
module lms_fir_lanes #(
    parameter int DW    = 16,
    parameter int TAPS  = 128,
    parameter int LANES = 4,
    parameter int ACCW  = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    lms_fir_lanes_if.slave bus
);

    localparam int GROUPS = TAPS / LANES;
    localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [GW-1:0] G_LAST = GW'(GROUPS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Sign-extend a DW value to the accumulator width.
    function automatic logic signed [ACCW-1:0] sext_w(input logic signed [DW-1:0] v);
        sext_w = {{(ACCW-DW){v[DW-1]}}, v};
    endfunction

    // Sign-extend a full product to the accumulator width.
    function automatic logic signed [ACCW-1:0] sext_2w(input logic signed [2*DW-1:0] v);
        sext_2w = {{(ACCW-2*DW){v[2*DW-1]}}, v};
    endfunction

    // Sign-extend a DW operand to product width so the multiply is exact.
    function automatic logic signed [2*DW-1:0] sext_p(input logic signed [DW-1:0] v);
        sext_p = {{DW{v[DW-1]}}, v};
    endfunction

    // Clamp an accumulator-width value into the signed DW range.
    function automatic logic signed [DW-1:0] sat_dw(input logic signed [ACCW-1:0] v);
        logic signed [ACCW-1:0] hi;
        logic signed [ACCW-1:0] lo;
        hi = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
        lo = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};
        if (v > hi) begin
            sat_dw = hi[DW-1:0];
        end else if (v < lo) begin
            sat_dw = lo[DW-1:0];
        end else begin
            sat_dw = v[DW-1:0];
        end
    endfunction

    // Architectural state
    logic signed [DW-1:0]   x_r [TAPS];
    logic signed [DW-1:0]   w_r [TAPS];
    logic [1:0]             state_r;
    logic [GW-1:0]          g_r;
    logic                   adapt_r;
    logic signed [DW-1:0]   wadj_r;
    logic signed [ACCW-1:0] acc_r;
    logic                   acc_last_r;
    logic                   busy_r;
    logic signed [DW-1:0]   out_sample_r;
    logic                   out_valid_r;
    logic                   done_r;
    logic                   overrun_r;

    // Pipeline registers, one slot per lane
    logic                   s1_vld_r, s2_vld_r, s3_vld_r, s4_vld_r;
    logic                   s1_last_r, s2_last_r, s3_last_r, s4_last_r;
    logic [GW-1:0]          s1_g_r, s2_g_r;
    logic signed [DW-1:0]   s1_x_r [LANES];
    logic signed [DW-1:0]   s1_w_r [LANES];
    logic signed [2*DW-1:0] p_r    [LANES];
    logic signed [DW-1:0]   s2_x_r [LANES];
    logic signed [DW-1:0]   s2_w_r [LANES];
    logic signed [DW-1:0]   wn_r   [LANES];
    logic signed [DW-1:0]   s3_x_r [LANES];
    logic signed [2*DW-1:0] q_r    [LANES];

    // Combinational lane datapath
    logic signed [2*DW-1:0] p_s     [LANES];
    logic signed [DW-1:0]   w_new_s [LANES];
    logic signed [2*DW-1:0] q_s     [LANES];
    logic signed [ACCW-1:0] lane_sum_s;
    logic                   accept_s;
    logic                   clr_s;
    logic                   issue_s;

    assign accept_s = (state_r == ST_IDLE) && bus.fir_go;
    assign clr_s    = (state_r == ST_IDLE) && !bus.fir_go && bus.weight_clr;
    assign issue_s  = (state_r == ST_RUN);

    assign bus.busy       = busy_r;
    assign bus.out_sample = out_sample_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.done       = done_r;
    assign bus.overrun    = overrun_r;

    // Lane arithmetic: update product, saturated weight update, output product, lane sum.
    always_comb begin
        lane_sum_s = '0;
        for (int j = 0; j < LANES; j++) begin
            p_s[j] = sext_p(wadj_r) * sext_p(s1_x_r[j]);
            if (adapt_r) begin
                w_new_s[j] = sat_dw(sext_w(s2_w_r[j]) + (sext_2w(p_r[j]) >>> (DW-1)));
            end else begin
                w_new_s[j] = s2_w_r[j];
            end
            q_s[j]     = sext_p(wn_r[j]) * sext_p(s3_x_r[j]);
            lane_sum_s = lane_sum_s + sext_2w(q_r[j]);
        end
    end

    // Delay line: shifts only when a run is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) x_r[k] <= '0;
        end else if (accept_s) begin
            x_r[0] <= bus.x_in;
            for (int k = 1; k < TAPS; k++) x_r[k] <= x_r[k-1];
        end
    end

    // Weight memory: idle clear, or write-back from the update stage when adapting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) w_r[k] <= '0;
        end else if (clr_s) begin
            for (int k = 0; k < TAPS; k++) w_r[k] <= '0;
        end else if (s2_vld_r && adapt_r) begin
            for (int j = 0; j < LANES; j++) w_r[int'(s2_g_r) * LANES + j] <= w_new_s[j];
        end
    end

    // Lane pipeline: read, update multiply, weight write/forward, output multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1_vld_r, s2_vld_r, s3_vld_r, s4_vld_r}     <= 4'b0000;
            {s1_last_r, s2_last_r, s3_last_r, s4_last_r} <= 4'b0000;
            s1_g_r <= '0;
            s2_g_r <= '0;
            for (int j = 0; j < LANES; j++) begin
                s1_x_r[j] <= '0;
                s1_w_r[j] <= '0;
                p_r[j]    <= '0;
                s2_x_r[j] <= '0;
                s2_w_r[j] <= '0;
                wn_r[j]   <= '0;
                s3_x_r[j] <= '0;
                q_r[j]    <= '0;
            end
        end else begin
            s1_vld_r  <= issue_s;
            s1_last_r <= issue_s && (g_r == G_LAST);
            s1_g_r    <= g_r;
            s2_vld_r  <= s1_vld_r;
            s2_last_r <= s1_last_r;
            s2_g_r    <= s1_g_r;
            s3_vld_r  <= s2_vld_r;
            s3_last_r <= s2_last_r;
            s4_vld_r  <= s3_vld_r;
            s4_last_r <= s3_last_r;
            for (int j = 0; j < LANES; j++) begin
                s1_x_r[j] <= x_r[int'(g_r) * LANES + j];
                s1_w_r[j] <= w_r[int'(g_r) * LANES + j];
                p_r[j]    <= p_s[j];
                s2_x_r[j] <= s1_x_r[j];
                s2_w_r[j] <= s1_w_r[j];
                wn_r[j]   <= w_new_s[j];
                s3_x_r[j] <= s2_x_r[j];
                q_r[j]    <= q_s[j];
            end
        end
    end

    // Accumulator: preloaded with a_in aligned to product scale, then summed per group.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r      <= '0;
            acc_last_r <= 1'b0;
        end else begin
            acc_last_r <= s4_vld_r && s4_last_r;
            if (accept_s) begin
                acc_r <= sext_w(bus.a_in) <<< (DW-1);
            end else if (s4_vld_r) begin
                acc_r <= acc_r + lane_sum_s;
            end
        end
    end

    // Control FSM: accept, issue groups, wait for the last accumulate, present result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            g_r          <= '0;
            adapt_r      <= 1'b0;
            wadj_r       <= '0;
            busy_r       <= 1'b0;
            out_sample_r <= '0;
            out_valid_r  <= 1'b0;
            done_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            overrun_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.fir_go) begin
                        state_r <= ST_RUN;
                        g_r     <= '0;
                        adapt_r <= bus.adapt_en;
                        wadj_r  <= bus.weight_adjust;
                        busy_r  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    overrun_r <= bus.fir_go;
                    if (g_r == G_LAST) begin
                        state_r <= ST_DRAIN;
                    end else begin
                        g_r <= g_r + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // fir_go on the result edge still counts as an overrun
                    overrun_r <= bus.fir_go;
                    if (acc_last_r) begin
                        out_sample_r <= sat_dw(acc_r >>> (DW-1));
                        out_valid_r  <= 1'b1;
                        done_r       <= 1'b1;
                        busy_r       <= 1'b0;
                        state_r      <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lms_fir_lanes.sv
// Scoreboard bench for lms_fir_lanes (TAPS=128, LANES=4), plus LANES=1/8 latency copies.
module tb_lms_fir_lanes;
    localparam int LAT4 = 37;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    lms_fir_lanes_if #(.DW(16)) ifc ();
    lms_fir_lanes_if #(.DW(16)) ifc1 ();
    lms_fir_lanes_if #(.DW(16)) ifc8 ();

    lms_fir_lanes #(.DW(16), .TAPS(128), .LANES(4), .ACCW(40)) dut  (.clk(clk), .rst_n(rst_n), .bus(ifc));
    lms_fir_lanes #(.DW(16), .TAPS(128), .LANES(1), .ACCW(40)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
    lms_fir_lanes #(.DW(16), .TAPS(128), .LANES(8), .ACCW(40)) dut8 (.clk(clk), .rst_n(rst_n), .bus(ifc8));

    assign ifc1.x_in = ifc.x_in;  assign ifc1.a_in = ifc.a_in;
    assign ifc1.weight_adjust = ifc.weight_adjust;  assign ifc1.adapt_en = ifc.adapt_en;
    assign ifc1.weight_clr = ifc.weight_clr;
    assign ifc8.x_in = ifc.x_in;  assign ifc8.a_in = ifc.a_in;
    assign ifc8.weight_adjust = ifc.weight_adjust;  assign ifc8.adapt_en = ifc.adapt_en;
    assign ifc8.weight_clr = ifc.weight_clr;

    typedef struct {
        logic signed [15:0] val;
        int                 at;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int ovr_cnt = 0;
    int vld_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops the scoreboard whenever a result is presented.
    always @(negedge clk) begin
        exp_t e;
        if (ifc.out_valid) begin
            vld_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_sample", ifc.out_sample, e.val);
                check("out_cycle", cyc, e.at);
                check("done_with_valid", ifc.done, 1);
                check("busy_low_at_valid", ifc.busy, 0);
            end
        end
        if (ifc.overrun) ovr_cnt++;
    end

    task automatic issue(input logic signed [15:0] x, input logic signed [15:0] a,
                         input logic signed [15:0] wa, input logic ad, input int hold,
                         input bit expect_out, input logic signed [15:0] expv);
        exp_t e;
        @(negedge clk);
        ifc.x_in = x;  ifc.a_in = a;  ifc.weight_adjust = wa;  ifc.adapt_en = ad;
        ifc.fir_go = 1'b1;
        if (expect_out) begin
            e.val = expv;
            e.at  = cyc + 1 + LAT4;
            exp_q.push_back(e);
        end
        repeat (hold) @(negedge clk);
        ifc.fir_go = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((ifc.busy || exp_q.size() != 0) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check({name, "_timeout"}, n, 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int o0, v0, start, n;
        exp_t e;
        ifc.x_in = '0; ifc.a_in = '0; ifc.weight_adjust = '0;
        ifc.adapt_en = 1'b0; ifc.weight_clr = 1'b0; ifc.fir_go = 1'b0;
        ifc1.fir_go = 1'b0; ifc8.fir_go = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_busy", ifc.busy, 0);
        check("rst_out_sample", ifc.out_sample, 0);
        check("rst_done", ifc.done, 0);
        check("rst_overrun", ifc.overrun, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic adapt run
        issue(16'sd16384, 16'sd0, 16'sd16384, 1'b1, 1, 1'b1, 16'sd4096);
        check("busy_after_e0", ifc.busy, 1);
        repeat (36) @(negedge clk);
        check("busy_before_result", ifc.busy, 1);
        check("no_early_valid", ifc.out_valid, 0);
        wait_idle("basic");
        check("basic_w0", dut.w_r[0], 8192);
        check("basic_w1", dut.w_r[1], 0);

        // Weight clear in idle keeps the delay line
        ifc.weight_clr = 1'b1;
        @(negedge clk);
        ifc.weight_clr = 1'b0;
        check("clr_w0", dut.w_r[0], 0);
        check("clr_keeps_x0", dut.x_r[0], 16384);
        issue(16'sd0, 16'sd7, 16'sd0, 1'b0, 1, 1'b1, 16'sd7);
        wait_idle("clr_run");

        // Frozen pass-through
        do_reset();
        issue(16'sd12345, 16'sd1000, 16'sd16384, 1'b0, 1, 1'b1, 16'sd1000);
        wait_idle("frozen");
        check("frozen_w0", dut.w_r[0], 0);

        // Positive saturation over two runs
        do_reset();
        issue(16'sd32767, 16'sd0, 16'sd32767, 1'b1, 1, 1'b1, 16'sd32765);
        wait_idle("satp1");
        check("satp1_w0", dut.w_r[0], 32766);
        issue(16'sd32767, 16'sd0, 16'sd32767, 1'b1, 1, 1'b1, 16'sd32767);
        wait_idle("satp2");
        check("satp2_w0", dut.w_r[0], 32767);
        check("satp2_w1", dut.w_r[1], 32766);

        // Negative saturation over two runs
        do_reset();
        issue(16'sd32767, 16'sd0, -16'sd32767, 1'b1, 1, 1'b1, -16'sd32767);
        wait_idle("satn1");
        issue(16'sd32767, 16'sd0, -16'sd32767, 1'b1, 1, 1'b1, -16'sd32768);
        wait_idle("satn2");
        check("satn2_w0", dut.w_r[0], -32768);
        check("satn2_w1", dut.w_r[1], -32767);

        // fir_go held three cycles: one run, two overruns
        do_reset();
        o0 = ovr_cnt;  v0 = vld_cnt;
        issue(16'sd16384, 16'sd0, 16'sd16384, 1'b1, 3, 1'b1, 16'sd4096);
        wait_idle("held_go");
        check("held_go_overruns", ovr_cnt - o0, 2);
        check("held_go_valids", vld_cnt - v0, 1);

        // fir_go on the result edge is an overrun; the next cycle is accepted
        do_reset();
        o0 = ovr_cnt;
        issue(16'sd16384, 16'sd0, 16'sd16384, 1'b1, 1, 1'b1, 16'sd4096);
        repeat (36) @(negedge clk);
        ifc.fir_go = 1'b1;
        e.val = 16'sd12288;
        e.at  = cyc + 2 + LAT4;
        exp_q.push_back(e);
        repeat (2) @(negedge clk);
        ifc.fir_go = 1'b0;
        wait_idle("back_to_back");
        check("b2b_overruns", ovr_cnt - o0, 1);

        // Reset mid-run aborts and zeroes weights
        do_reset();
        v0 = vld_cnt;
        issue(16'sd16384, 16'sd0, 16'sd16384, 1'b1, 1, 1'b0, 16'sd0);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", ifc.busy, 0);
        check("midrst_out_sample", ifc.out_sample, 0);
        check("midrst_w0", dut.w_r[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (60) @(negedge clk);
        check("midrst_no_valid", vld_cnt - v0, 0);
        issue(16'sd16384, 16'sd0, 16'sd16384, 1'b1, 1, 1'b1, 16'sd4096);
        wait_idle("after_midrst");

        // LANES=1 and LANES=8 latency and result
        do_reset();
        ifc.x_in = 16'sd16384; ifc.a_in = 16'sd0; ifc.weight_adjust = 16'sd16384; ifc.adapt_en = 1'b1;
        ifc1.fir_go = 1'b1;
        start = cyc;
        @(negedge clk);
        ifc1.fir_go = 1'b0;
        n = 0;
        while (!ifc1.out_valid && n < 300) begin @(negedge clk); n++; end
        check("lanes1_latency", cyc - start - 1, 133);
        check("lanes1_out", ifc1.out_sample, 4096);
        ifc8.fir_go = 1'b1;
        start = cyc;
        @(negedge clk);
        ifc8.fir_go = 1'b0;
        n = 0;
        while (!ifc8.out_valid && n < 300) begin @(negedge clk); n++; end
        check("lanes8_latency", cyc - start - 1, 21);
        check("lanes8_out", ifc8.out_sample, 4096);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
